// File: rtl/mux_4to1.sv
// Registered 4-to-1 multiplexer. The select is decoded per data bit in a
// small lane module, and the chosen word is captured into the single
// WIDTH-bit output register when enabled.

// One bit of the 4:1 selector. This is pure combinational logic.
module mux_4to1_lane (
  input  logic       i_d0,
  input  logic       i_d1,
  input  logic       i_d2,
  input  logic       i_d3,
  input  logic [1:0] i_sel,
  output logic       o_y
);

  // Full case. The default arm falls back to input 0, so no latch is
  // inferred for illegal (X/Z) select values.
  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'b00:   o_y = i_d0;
      2'b01:   o_y = i_d1;
      2'b10:   o_y = i_d2;
      2'b11:   o_y = i_d3;
      default: o_y = i_d0;
    endcase
  end

endmodule

module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic             in5,
  input  logic             in6,
  output logic [WIDTH-1:0] out1
);

  logic [1:0]       w_sel;
  logic [WIDTH-1:0] w_mux_next;
  logic [WIDTH-1:0] r_out;

  assign w_sel = {in6, in5};

  // Each bit is steered independently. Every lane shares the same select.
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    mux_4to1_lane u_lane (
      .i_d0  (in1[g]),
      .i_d1  (in2[g]),
      .i_d2  (in3[g]),
      .i_d3  (in4[g]),
      .i_sel (w_sel),
      .o_y   (w_mux_next[g])
    );
  end

  // Output register: cleared asynchronously by reset, loaded only when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_out <= '0;
    else if (en) r_out <= w_mux_next;
  end

  assign out1 = r_out;

endmodule

// File: tb/tb_mux_4to1.sv
// Bench for mux_4to1. A WIDTH=1 instance and a WIDTH=8 instance run side by
// side, and both are checked against an array-indexing reference model.
module tb_mux_4to1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] d8 [4];
  logic [1:0] s8;
  logic [3:0] d1;
  logic [1:0] s1;
  logic [7:0] o8;
  logic [0:0] o1;
  logic [7:0] m8;
  logic       m1;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  mux_4to1 #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst_n (rst_n), .en (en),
    .in1 (d8[0]), .in2 (d8[1]), .in3 (d8[2]), .in4 (d8[3]),
    .in5 (s8[0]), .in6 (s8[1]), .out1 (o8)
  );

  mux_4to1 #(.WIDTH(1)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .en (en),
    .in1 (d1[0]), .in2 (d1[1]), .in3 (d1[2]), .in4 (d1[3]),
    .in5 (s1[0]), .in6 (s1[1]), .out1 (o1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the output is the word picked by the select index.
  // It is updated at a rising edge from the values that were present before the edge.
  task automatic step(input string tag);
    logic [7:0] nx8;
    logic       nx1;
    nx8 = d8[s8];
    nx1 = d1[s1];
    @(posedge clk);
    if (!rst_n)  begin m8 = 8'h00; m1 = 1'b0; end
    else if (en) begin m8 = nx8;   m1 = nx1;  end
    #1;
    chk({tag, "/w8"}, o8, m8);
    chk({tag, "/w1"}, {7'd0, o1}, {7'd0, m1});
  endtask

  task automatic set8(input logic [7:0] a, b, c, d);
    d8[0] = a; d8[1] = b; d8[2] = c; d8[3] = d;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1;
    set8(8'h01, 8'h01, 8'h01, 8'h01); s8 = 2'b00;
    d1 = 4'b1111; s1 = 2'b00;
    m8 = 8'h00; m1 = 1'b0;
    #1;
    chk("reset_imm/w8", o8, 8'h00);
    chk("reset_imm/w1", {7'd0, o1}, 8'h00);
    for (int i = 0; i < 3; i++) step("reset_hold");

    // The release is aligned to a falling edge. The first capture selects in1 (1).
    @(negedge clk); rst_n = 1'b1;
    step("reset_rel");
    chk("reset_rel_val", o8, 8'h01);

    // Exhaustive test of the 1-bit instance, one vector per cycle.
    for (int v = 0; v < 64; v++) begin
      @(negedge clk);
      d1 = v[3:0]; s1 = v[5:4];
      set8(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      s8 = 2'($urandom);
      step("exhaustive");
    end

    // Select walk.
    @(negedge clk); set8(8'h11, 8'h22, 8'h33, 8'h44);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk); s8 = 2'(s);
      step("walk");
    end
    chk("walk_last", o8, 8'h44);

    // Hold while disabled.
    @(negedge clk); s8 = 2'b01; step("hold_cap");
    chk("hold_cap_val", o8, 8'h22);
    @(negedge clk); en = 1'b0; s8 = 2'b11; d8[3] = 8'hFF;
    for (int i = 0; i < 4; i++) step("hold");
    chk("hold_val", o8, 8'h22);
    @(negedge clk); en = 1'b1; step("hold_rel");
    chk("hold_rel_val", o8, 8'hFF);

    // Reset in the middle of operation. No capture may occur while reset is low, even with en=1.
    @(negedge clk); d8[3] = 8'h44; step("mid_pre");
    @(negedge clk); #2 rst_n = 1'b0; m8 = 8'h00; m1 = 1'b0; #1;
    chk("mid_async", o8, 8'h00);
    step("mid_in_rst");
    @(negedge clk); rst_n = 1'b1;
    step("mid_rel");
    chk("mid_rel_val", o8, 8'h44);

    // Select and data change at the same edge.
    @(negedge clk); s8 = 2'b00; d8[2] = 8'h33; step("simul_pre");
    @(negedge clk); s8 = 2'b10; d8[2] = 8'h5A; step("simul");
    chk("simul_val", o8, 8'h5A);

    // Random traffic with enable toggling and occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      set8(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      s8 = 2'($urandom); d1 = 4'($urandom); s1 = 2'($urandom);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0; m8 = 8'h00; m1 = 1'b0; #1;
        chk("rand_rst/w8", o8, 8'h00);
        chk("rand_rst/w1", {7'd0, o1}, 8'h00);
        step("rand_in_rst");
        @(negedge clk); rst_n = 1'b1;
      end
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
